vote_round_controller: RTL and testbench
========================================

Name: vote_round_controller

Overview:
- Sequences one 2-of-3 majority decision per round.
- Collects one vote from each of three independent voters over per-voter valid/ready handshakes, with a bounded collection window.
- Evaluates the majority through the team's gate-level majority cell and presents the result on a valid/ready output port.
- Sits between three redundant producers and a single consumer that needs a voted bit.

Parameters:
- TIMEOUT_CYCLES, 15: maximum cycles spent in COLLECT before forcing a decision; legal range 2..2^CNT_W-1.
- CNT_W, 4: width of the collection timer.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- start  input  1  begin a round; sampled only in IDLE.
- vote_valid  input  3  bit i: voter i presents a vote.
- vote  input  3  bit i: voter i's vote value.
- vote_ready  output  3  bit i: controller accepts voter i this cycle.
- result_valid  output  1  result held stable until accepted.
- result_ready  input  1  consumer accepts the result.
- result  output  1  majority value.
- timed_out  output  1  qualifies result: the round ended by timeout.
- missing  output  3  qualifies result: voters that never delivered a vote.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset is synchronous, active-low, and has priority over every other input. On reset:
  - State goes to IDLE.
  - All outputs are 0.
  - Captured votes, captured mask and timer are cleared.
- Reset asserted mid-round abandons the round; no result is produced.
- States are IDLE, COLLECT, DECIDE, RESULT.
- IDLE:
  - start=1 moves to COLLECT next cycle.
  - Entering COLLECT clears the captured mask and votes, and sets the timer to 0.
- COLLECT:
  - vote_ready[i] = ~captured[i]; purely registered-state driven, with no combinational path from vote_valid.
  - A handshake on voter i (vote_valid[i] & vote_ready[i]) registers vote[i] and sets captured[i].
  - Several voters may hand off in the same cycle.
  - The timer increments every cycle spent in COLLECT.
  - Go to DECIDE when the captured mask is 111, counting handshakes in the current cycle.
  - Otherwise go to DECIDE when the timer equals TIMEOUT_CYCLES-1; timeout_flag is set unless the mask became 111 in that same cycle.
  - If full capture and timeout occur in the same cycle, the full capture wins and timed_out=0.
- DECIDE (one cycle):
  - vote_ready = 000.
  - Missing votes are substituted with 0.
  - result_reg = majority3(v0, v1, v2).
  - missing_reg = ~captured.
  - Always moves to RESULT.
- RESULT:
  - result_valid=1; result, timed_out and missing are held constant.
  - On result_ready=1, go to IDLE.
  - start is ignored in RESULT; a new round requires start in IDLE. Back-to-back rounds therefore cost at least one IDLE cycle.
- result, timed_out and missing are 0 whenever result_valid=0.
- Latency with all voters delivering in the first COLLECT cycle: start at cycle 0, COLLECT at 1, DECIDE at 2, result_valid at 3.
- Votes offered in IDLE, DECIDE or RESULT are not accepted.
- Timer width rule: the comparison is against the CNT_W-bit constant TIMEOUT_CYCLES-1; the timer never wraps.

Optional Feature:
- Macro: VOTE_STATS_EN.
- When defined, adds output ports:
  - round_count  8 bits: saturating count of accepted results.
  - disagree_count  8 bits: saturating count of accepted results whose three captured votes were not unanimous, or whose round timed out.
- Both counters clear on reset, increment on the RESULT handshake, and saturate at 255.
- When undefined, these ports and registers do not exist and all other behaviour is identical.

Decomposition:
- Shared package vote_pkg:
  - State encoding constants: IDLE=2'd0, COLLECT=2'd1, DECIDE=2'd2, RESULT=2'd3.
  - NUM_VOTERS=3.
  - Stats counter width 8.
- Sub-module majority3: the existing gate-level 2-of-3 cell (in0, in1, in2 to out), instantiated once in DECIDE's datapath.
- Everything else stays in the top module.

Test Plan:
- Unanimous round: start, then vote_valid=111 and vote=101 in the first COLLECT cycle -> result_valid at cycle 3, result=1, timed_out=0, missing=000.
- Staggered handshakes: voter 0 vote=0 at cycle 1, voter 2 vote=1 at cycle 4, voter 1 vote=1 at cycle 6 -> vote_ready bits drop individually after each capture; result=1, missing=000.
- Timeout with TIMEOUT_CYCLES=15 and only voter 1 delivering vote=1 -> DECIDE after the 15th COLLECT cycle; result=0, timed_out=1, missing=101.
- Backpressure: hold result_ready=0 for 10 cycles with start pulsed throughout -> result and qualifiers held stable, no new round starts, and IDLE is reached one cycle after result_ready=1.
- Reset mid-round: rst_n=0 during COLLECT with 2 votes captured -> next cycle all outputs 0 and IDLE; a following round ignores the stale votes.
- VOTE_STATS_EN defined: 300 rounds including 5 timeouts -> round_count=255 (saturated), and disagree_count equals the reference-model count.

Source files
------------

// File: rtl/vote_pkg.sv
// Shared types and constants for the 2-of-3 vote round controller.
// Optional statistics counters are enabled by the VOTE_STATS_EN macro.
package vote_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DECIDE  = 2'd2,
      RESULT  = 2'd3
   } state_t;

   localparam int NUM_VOTERS = 3;
   localparam int STATS_W    = 8;

   function automatic logic is_unanimous(input logic [NUM_VOTERS-1:0] v);
      return (v == '0) || (v == '1);
   endfunction

endpackage

// File: rtl/vote_round_controller_if.sv
// Voter/consumer handshake bundle; slave = controller side, master = environment side.
// Statistics signals exist only when VOTE_STATS_EN is defined.
interface vote_round_controller_if;
   import vote_pkg::*;

   logic                  start;
   logic [NUM_VOTERS-1:0] vote_valid;
   logic [NUM_VOTERS-1:0] vote;
   logic [NUM_VOTERS-1:0] vote_ready;
   logic                  result_valid;
   logic                  result_ready;
   logic                  result;
   logic                  timed_out;
   logic [NUM_VOTERS-1:0] missing;
   logic                  busy;
`ifdef VOTE_STATS_EN
   logic [STATS_W-1:0]    round_count;
   logic [STATS_W-1:0]    disagree_count;
`endif

   modport slave (
      input  start, vote_valid, vote, result_ready,
      output vote_ready, result_valid, result, timed_out, missing, busy
`ifdef VOTE_STATS_EN
      , output round_count, disagree_count
`endif
   );

   modport master (
      output start, vote_valid, vote, result_ready,
      input  vote_ready, result_valid, result, timed_out, missing, busy
`ifdef VOTE_STATS_EN
      , input round_count, disagree_count
`endif
   );

endinterface

// File: rtl/majority3.sv
// Gate-level 2-of-3 majority cell: out = ab | ac | bc. Purely combinational.
module majority3 (
   input  logic in0,
   input  logic in1,
   input  logic in2,
   output logic out
);

   wire w_ab;
   wire w_ac;
   wire w_bc;

   and u_ab (w_ab, in0, in1);
   and u_ac (w_ac, in0, in2);
   and u_bc (w_bc, in1, in2);
   or  u_or (out, w_ab, w_ac, w_bc);

endmodule

// File: rtl/vote_round_controller.sv
// One 2-of-3 majority round per start: COLLECT (bounded) -> DECIDE -> RESULT, result held until accepted.
// vote_ready comes from registered state only; VOTE_STATS_EN adds saturating round/disagree counters.
module vote_round_controller
   import vote_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 15,
   parameter int CNT_W          = 4
) (
   input logic                   clk,
   input logic                   rst_n,
   vote_round_controller_if.slave bus
);

   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t                r_state;
   state_t                w_next_state;
   logic [NUM_VOTERS-1:0] r_captured;
   logic [NUM_VOTERS-1:0] r_votes;
   logic [CNT_W-1:0]      r_timer;
   logic                  r_timeout_flag;
   logic                  r_result;
   logic                  r_timed_out;
   logic [NUM_VOTERS-1:0] r_missing;

   logic [NUM_VOTERS-1:0] w_vote_ready;
   logic [NUM_VOTERS-1:0] w_hs;
   logic                  w_full;
   logic                  w_tmo_hit;
   logic [NUM_VOTERS-1:0] w_v_sub;
   logic                  w_maj;
   logic                  w_res_vld;
   logic                  w_res_hs;

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      w_vote_ready = '0;
      w_hs         = '0;
      w_full       = 1'b0;
      w_tmo_hit    = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.start) w_next_state = COLLECT;
         end
         COLLECT: begin
            w_vote_ready = ~r_captured;
            w_hs         = bus.vote_valid & w_vote_ready;
            w_full       = &(r_captured | w_hs);
            w_tmo_hit    = (r_timer == TMO_LAST);
            if (w_full || w_tmo_hit) w_next_state = DECIDE;
         end
         DECIDE: begin
            w_next_state = RESULT;
         end
         RESULT: begin
            if (bus.result_ready) w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   // Uncaptured voters read as 0 because their vote bits are masked off here.
   assign w_v_sub = r_votes & r_captured;

   majority3 u_majority3 (
      .in0 (w_v_sub[0]),
      .in1 (w_v_sub[1]),
      .in2 (w_v_sub[2]),
      .out (w_maj)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_captured     <= '0;
         r_votes        <= '0;
         r_timer        <= '0;
         r_timeout_flag <= 1'b0;
         r_result       <= 1'b0;
         r_timed_out    <= 1'b0;
         r_missing      <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_captured     <= '0;
                  r_votes        <= '0;
                  r_timer        <= '0;
                  r_timeout_flag <= 1'b0;
               end
            end
            COLLECT: begin
               r_captured     <= r_captured | w_hs;
               r_votes        <= (r_votes & ~w_hs) | (bus.vote & w_hs);
               r_timeout_flag <= w_tmo_hit & ~w_full;
               // Timer stops at TMO_LAST so it can never wrap.
               if (!w_tmo_hit) r_timer <= r_timer + 1'b1;
            end
            DECIDE: begin
               r_result    <= w_maj;
               r_missing   <= ~r_captured;
               r_timed_out <= r_timeout_flag;
            end
            default: ;
         endcase
      end
   end

   assign w_res_vld = (r_state == RESULT);
   assign w_res_hs  = w_res_vld & bus.result_ready;

   assign bus.vote_ready   = w_vote_ready;
   assign bus.result_valid = w_res_vld;
   assign bus.result       = w_res_vld & r_result;
   assign bus.timed_out    = w_res_vld & r_timed_out;
   assign bus.missing      = w_res_vld ? r_missing : '0;
   assign bus.busy         = (r_state != IDLE);

`ifdef VOTE_STATS_EN
   logic               r_disagree;
   logic [STATS_W-1:0] r_round_count;
   logic [STATS_W-1:0] r_disagree_count;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_disagree       <= 1'b0;
         r_round_count    <= '0;
         r_disagree_count <= '0;
      end else begin
         if (r_state == DECIDE)
            r_disagree <= r_timeout_flag | ~is_unanimous(w_v_sub);
         if (w_res_hs) begin
            if (r_round_count != '1)
               r_round_count <= r_round_count + 1'b1;
            if (r_disagree && (r_disagree_count != '1))
               r_disagree_count <= r_disagree_count + 1'b1;
         end
      end
   end

   assign bus.round_count    = r_round_count;
   assign bus.disagree_count = r_disagree_count;
`else
   logic w_unused_hs;
   assign w_unused_hs = w_res_hs;
`endif

endmodule

// File: tb/tb_vote_round_controller.sv
// Directed-vector bench for vote_round_controller; stats checks compile in with VOTE_STATS_EN.
module tb_vote_round_controller;

   logic clk = 1'b0;
   logic rst_n;
   int   n_vec  = 0;
   int   n_miss = 0;

   always #5 clk = ~clk;

   vote_round_controller_if vif ();

   vote_round_controller #(.TIMEOUT_CYCLES(15), .CNT_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (vif)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk_result(input string tag, input int rv, input int res, input int tmo, input int mis);
      chk({tag, ".result_valid"}, 32'(vif.result_valid), rv);
      chk({tag, ".result"},       32'(vif.result),       res);
      chk({tag, ".timed_out"},    32'(vif.timed_out),    tmo);
      chk({tag, ".missing"},      32'(vif.missing),      mis);
   endtask

   task automatic wait_result(input int bound);
      int n = 0;
      while (vif.result_valid !== 1'b1 && n < bound) begin
         tick();
         n++;
      end
      chk("wait_result", 32'(vif.result_valid), 1);
   endtask

   task automatic accept();
      vif.result_ready = 1'b1;
      tick();
      vif.result_ready = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n            = 1'b0;
      vif.start        = 1'b0;
      vif.vote_valid   = '0;
      vif.vote         = '0;
      vif.result_ready = 1'b0;
      repeat (3) tick();
      chk("rst.busy", 32'(vif.busy), 0);
      chk("rst.vote_ready", 32'(vif.vote_ready), 0);
      chk_result("rst", 0, 0, 0, 0);
      rst_n = 1'b1;
      tick();

      // Unanimous round, all votes in the first COLLECT cycle.
      vif.start = 1'b1;
      tick();
      vif.start = 1'b0;
      chk("u.busy", 32'(vif.busy), 1);
      chk("u.ready_c1", 32'(vif.vote_ready), 7);
      vif.vote_valid = 3'b111; vif.vote = 3'b101;
      tick();
      vif.vote_valid = '0;
      chk("u.ready_decide", 32'(vif.vote_ready), 0);
      chk("u.rv_decide", 32'(vif.result_valid), 0);
      tick();
      chk_result("u.c3", 1, 1, 0, 0);
      accept();
      chk("u.busy_after", 32'(vif.busy), 0);
      chk_result("u.after", 0, 0, 0, 0);

      // Staggered handshakes.
      vif.start = 1'b1;
      tick();
      vif.start = 1'b0;
      vif.vote_valid = 3'b001; vif.vote = 3'b000;
      tick();
      vif.vote_valid = '0;
      chk("s.ready_c2", 32'(vif.vote_ready), 6);
      tick(); tick();
      vif.vote_valid = 3'b100; vif.vote = 3'b100;
      tick();
      vif.vote_valid = '0;
      chk("s.ready_c5", 32'(vif.vote_ready), 2);
      tick();
      vif.vote_valid = 3'b010; vif.vote = 3'b010;
      tick();
      vif.vote_valid = '0;
      chk("s.ready_c7", 32'(vif.vote_ready), 0);
      tick();
      chk_result("s.c8", 1, 1, 0, 0);
      accept();

      // Timeout with only voter 1, followed by backpressure.
      vif.start = 1'b1;
      tick();
      vif.start = 1'b0;
      vif.vote_valid = 3'b010; vif.vote = 3'b010;
      tick();
      vif.vote_valid = '0;
      repeat (13) tick();
      chk("t.busy_c15", 32'(vif.busy), 1);
      chk("t.ready_c15", 32'(vif.vote_ready), 5);
      tick();
      chk("t.ready_c16", 32'(vif.vote_ready), 0);
      chk("t.rv_c16", 32'(vif.result_valid), 0);
      tick();
      chk_result("t.c17", 1, 0, 1, 5);
      vif.start = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk_result("bp.hold", 1, 0, 1, 5);
         chk("bp.busy", 32'(vif.busy), 1);
      end
      vif.start = 1'b0;
      accept();
      chk("bp.busy_after", 32'(vif.busy), 0);
      chk("bp.rv_after", 32'(vif.result_valid), 0);

      // Full capture lands on the timeout cycle: capture wins.
      vif.start = 1'b1;
      tick();
      vif.start = 1'b0;
      vif.vote_valid = 3'b001; vif.vote = 3'b001;
      tick();
      vif.vote_valid = '0; vif.vote = '0;
      repeat (13) tick();
      vif.vote_valid = 3'b110; vif.vote = 3'b010;
      tick();
      vif.vote_valid = '0;
      chk("ft.rv_c16", 32'(vif.result_valid), 0);
      tick();
      chk_result("ft.c17", 1, 1, 0, 0);
      accept();

      // Reset mid-round; votes offered in IDLE alongside start are ignored.
      vif.start = 1'b1; vif.vote_valid = 3'b111; vif.vote = 3'b111;
      tick();
      vif.start = 1'b0;
      chk("r.ready_c1", 32'(vif.vote_ready), 7);
      vif.vote_valid = 3'b011; vif.vote = 3'b011;
      tick();
      vif.vote_valid = '0;
      chk("r.ready_c2", 32'(vif.vote_ready), 4);
      rst_n = 1'b0;
      tick();
      chk("r.busy", 32'(vif.busy), 0);
      chk("r.ready", 32'(vif.vote_ready), 0);
      chk_result("r.rst", 0, 0, 0, 0);
      rst_n = 1'b1;
      tick();
      vif.start = 1'b1;
      tick();
      vif.start = 1'b0;
      chk("r2.ready_c1", 32'(vif.vote_ready), 7);
      vif.vote_valid = 3'b100; vif.vote = 3'b000;
      tick();
      vif.vote_valid = '0;
      wait_result(40);
      chk_result("r2.res", 1, 0, 1, 3);
      accept();

`ifdef VOTE_STATS_EN
      begin
         int  exp_rounds = 0;
         int  exp_dis    = 0;
         logic [2:0] pat;
         logic tmo;
         logic exp_res;
         logic dis;
         rst_n = 1'b0;
         tick();
         rst_n = 1'b1;
         chk("st.round_rst", 32'(vif.round_count), 0);
         chk("st.dis_rst", 32'(vif.disagree_count), 0);
         for (int r = 0; r < 300; r++) begin
            tmo = (r % 60 == 7);
            if (r % 4 == 0)      pat = 3'b010;
            else if (r % 2 == 1) pat = 3'b111;
            else                 pat = 3'b000;
            vif.start = 1'b1;
            tick();
            vif.start = 1'b0;
            if (tmo) begin
               vif.vote_valid = 3'b001; vif.vote = 3'b001;
               exp_res = 1'b0;
               dis     = 1'b1;
            end else begin
               vif.vote_valid = 3'b111; vif.vote = pat;
               exp_res = pat[0] ? (pat[1] | pat[2]) : (pat[1] & pat[2]);
               dis     = !(pat == 3'b000 || pat == 3'b111);
            end
            tick();
            vif.vote_valid = '0;
            wait_result(40);
            chk("st.result", 32'(vif.result), 32'(exp_res));
            accept();
            if (exp_rounds < 255) exp_rounds++;
            if (dis && exp_dis < 255) exp_dis++;
         end
         chk("st.round_count", 32'(vif.round_count), exp_rounds);
         chk("st.disagree_count", 32'(vif.disagree_count), exp_dis);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
